// File: rtl/pes_add_pkg.sv
// Shared helpers for the pipelined adder tree: default widths, clog2 and the
// sign/zero extension used by every adder level and the accumulator.
package pes_add_pkg;

  localparam int N_IN_DEF = 8;
  localparam int IN_W_DEF = 8;
  localparam int EXT_W    = 64;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (32'sd1 << r) < n; r++) begin
    end
    return r;
  endfunction

  // Bits at and above w are filled with the operand's top bit when sgn is set.
  function automatic logic [EXT_W-1:0] extend(input logic [EXT_W-1:0] v,
                                              input int w,
                                              input logic sgn);
    logic [EXT_W-1:0] r;
    for (int i = 0; i < EXT_W; i++) begin
      r[i] = (i < w) ? v[i] : (sgn & v[w-1]);
    end
    return r;
  endfunction

endpackage

// File: rtl/pes_add_level.sv
// One registered adder level: N operands of W bits reduced pairwise to N/2
// partial sums of W+1 bits, with its valid bit.
module pes_add_level
  import pes_add_pkg::*;
#(
  parameter int N      = 8,
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     prev_valid,
  input  logic [N*W-1:0]           prev_data,
  output logic                     valid,
  output logic [(N/2)*(W+1)-1:0]   data
);

  logic [(N/2)*(W+1)-1:0] sum;

  // Pairwise add of adjacent operands after widening by one bit.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N/2; i++) begin
      sum[i*(W+1) +: W+1] =
          (W+1)'(extend(EXT_W'(prev_data[(2*i)*W +: W]), W, SIGNED != 0)) +
          (W+1)'(extend(EXT_W'(prev_data[(2*i+1)*W +: W]), W, SIGNED != 0));
    end
  end

  // Valid follows the previous level on advance; data loads only for real vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (adv) begin
        valid <= prev_valid;
      end
      if (adv && prev_valid) begin
        data <= sum;
      end
    end
  end

endmodule

// File: rtl/pes_add_tree_pipe.sv
// Pipelined N_IN-operand adder tree with valid/ready backpressure.
// Optional running accumulator on the output when PES_ADD_ACC_EN is defined.
module pes_add_tree_pipe
  import pes_add_pkg::*;
#(
  parameter  int N_IN   = N_IN_DEF,
  parameter  int IN_W   = IN_W_DEF,
  parameter  int SIGNED = 0,
  localparam int LEVELS = clog2(N_IN),
  localparam int OUT_W  = IN_W + LEVELS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*IN_W-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_sum
`ifdef PES_ADD_ACC_EN
  ,
  input  logic                  acc_clear,
  output logic [OUT_W+7:0]      acc_out
`endif
);

  localparam int BUS_W = N_IN * IN_W;

  logic [LEVELS:0]   v;
  logic [LEVELS+1:1] adv;
  logic [BUS_W-1:0]  lvl_data [0:LEVELS];

  assign v[0]        = in_valid;
  assign lvl_data[0] = in_data;

  // A level may load when it is empty or the level after it is moving too.
  always_comb begin
    adv             = '0;
    adv[LEVELS+1]   = out_ready;
    for (int l = LEVELS; l >= 1; l--) begin
      adv[l] = !v[l] || adv[l+1];
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int N  = N_IN >> (l - 1);
    localparam int W  = IN_W + l - 1;
    localparam int OW = (N / 2) * (W + 1);

    pes_add_level #(
      .N      (N),
      .W      (W),
      .SIGNED (SIGNED)
    ) u_level (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv[l]),
      .prev_valid (v[l-1]),
      .prev_data  (lvl_data[l-1][N*W-1:0]),
      .valid      (v[l]),
      .data       (lvl_data[l][OW-1:0])
    );

    if (OW < BUS_W) begin : g_pad
      assign lvl_data[l][BUS_W-1:OW] = '0;
    end
  end

  assign in_ready  = adv[1];
  assign out_valid = v[LEVELS];
  assign out_sum   = lvl_data[LEVELS][OUT_W-1:0];

`ifdef PES_ADD_ACC_EN
  localparam int ACC_W = OUT_W + 8;

  logic             xfer;
  logic [ACC_W-1:0] sum_ext;

  assign xfer    = out_valid && out_ready;
  assign sum_ext = ACC_W'(extend(EXT_W'(out_sum), OUT_W, SIGNED != 0));

  // Clear wins over accumulate but still captures a result transferring this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= '0;
    end else if (acc_clear) begin
      acc_out <= xfer ? sum_ext : '0;
    end else if (xfer) begin
      acc_out <= acc_out + sum_ext;
    end else begin
      acc_out <= acc_out;
    end
  end
`endif

endmodule

// File: tb/tb_pes_add_tree_pipe.sv
// Bench for pes_add_tree_pipe: unsigned and signed instances share stimulus and
// are checked every cycle against a slot/scoreboard model plus literal results.
module tb_pes_add_tree_pipe;

  localparam int OUT_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [63:0]       in_data = 64'd0;
  logic              in_ready_u, in_ready_s, out_valid_u, out_valid_s;
  logic [OUT_W-1:0]  out_sum_u, out_sum_s;
`ifdef PES_ADD_ACC_EN
  logic              acc_clear = 1'b0;
  logic [OUT_W+7:0]  acc_u, acc_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // model: three pipeline slots, and the queue of accepted sums in order
  bit               mv [1:3];
  logic [OUT_W-1:0] mu [1:3];
  logic [OUT_W-1:0] ms [1:3];
  logic [OUT_W-1:0] sb_u[$], sb_s[$];
  logic [OUT_W-1:0] got_u[$], got_s[$];
  int               got_t[$];

  always #5 clk = ~clk;

  pes_add_tree_pipe #(.N_IN(8), .IN_W(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_sum(out_sum_u)
`ifdef PES_ADD_ACC_EN
    , .acc_clear(acc_clear), .acc_out(acc_u)
`endif
  );

  pes_add_tree_pipe #(.N_IN(8), .IN_W(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s)
`ifdef PES_ADD_ACC_EN
    , .acc_clear(acc_clear), .acc_out(acc_s)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_sum(input logic [63:0] d, input bit sgn);
    int s;
    s = 0;
    for (int k = 0; k < 8; k++) begin
      if (sgn) s += int'($signed(d[k*8 +: 8]));
      else     s += int'(d[k*8 +: 8]);
    end
    return s[OUT_W-1:0];
  endfunction

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Compare against the model state, then advance the model for the coming edge.
  always @(negedge clk) begin
    bit move;
    bit exp_ready;
    cycle++;
    if (rst) begin
      for (int l = 1; l <= 3; l++) begin
        mv[l] = 1'b0;
      end
      sb_u.delete();
      sb_s.delete();
    end else begin
      exp_ready = out_ready || !(mv[1] && mv[2] && mv[3]);
      chk("in_ready_u", in_ready_u, exp_ready);
      chk("in_ready_s", in_ready_s, exp_ready);
      chk("out_valid_u", out_valid_u, mv[3]);
      chk("out_valid_s", out_valid_s, mv[3]);
      if (mv[3]) begin
        chk("out_sum_u", out_sum_u, mu[3]);
        chk("out_sum_s", out_sum_s, ms[3]);
      end
      if (out_valid_u && out_ready) begin
        if (sb_u.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL order: result %0d with nothing accepted", out_sum_u);
        end else begin
          chk("order_u", out_sum_u, sb_u.pop_front());
          chk("order_s", out_sum_s, sb_s.pop_front());
        end
        got_u.push_back(out_sum_u);
        got_s.push_back(out_sum_s);
        got_t.push_back(cycle);
      end
      move = out_ready;
      for (int l = 3; l >= 1; l--) begin
        move = move || !mv[l];
        if (move) begin
          if (l == 1) begin
            mv[1] = in_valid;
            if (in_valid) begin
              mu[1] = ref_sum(in_data, 1'b0);
              ms[1] = ref_sum(in_data, 1'b1);
              sb_u.push_back(mu[1]);
              sb_s.push_back(ms[1]);
            end
          end else begin
            mv[l] = mv[l-1];
            if (mv[l-1]) begin
              mu[l] = mu[l-1];
              ms[l] = ms[l-1];
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready_u;
      step();
      n++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_got();
    got_u.delete();
    got_s.delete();
    got_t.delete();
  endtask

  logic [63:0] odd;
  int lat;

  initial begin
    odd = {8'd15, 8'd13, 8'd11, 8'd9, 8'd7, 8'd5, 8'd3, 8'd1};
    repeat (2) step();
    chk("rst_in_ready", in_ready_u, 1);
    chk("rst_out_valid", out_valid_u, 0);
    chk("rst_out_sum", out_sum_u, 0);
    rst = 1'b0;

    // basic sum and latency
    clear_got();
    push(odd);
    lat = 0;
    while (!out_valid_u && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    chk("basic_sum", out_sum_u, 11'd64);
    repeat (6) step();

    // maximum operands and back-to-back throughput
    clear_got();
    push(rep(8'd255));
    push(rep(8'd255));
    push(rep(8'd1));
    push(rep(8'd255));
    push(rep(8'd1));
    repeat (8) step();
    chk("max_count", got_u.size(), 5);
    chk("max_0", got_u[0], 11'h7F8);
    chk("b2b_1", got_u[1], 11'd2040);
    chk("b2b_2", got_u[2], 11'd8);
    chk("b2b_3", got_u[3], 11'd2040);
    chk("b2b_4", got_u[4], 11'd8);
    for (int i = 2; i < 5; i++) begin
      chk("b2b_spacing", got_t[i] - got_t[i-1], 1);
    end

    // signed extension
    clear_got();
    push(rep(8'h80));
    push({{4{8'h01}}, {4{8'hFF}}});
    repeat (8) step();
    chk("signed_min", got_s[0], 11'h400);
    chk("signed_zero", got_s[1], 11'd0);
    chk("unsigned_80", got_u[0], 11'd1024);
    chk("unsigned_mix", got_u[1], 11'd1024);

    // backpressure: three fill the pipe, the fourth waits
    out_ready = 1'b0;
    clear_got();
    push(odd);
    push(rep(8'd1));
    push(rep(8'd255));
    fork
      push(rep(8'd2));
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready_u, 0);
          chk("bp_hold_valid", out_valid_u, 1);
          chk("bp_hold_sum", out_sum_u, 11'd64);
        end
        step();
        out_ready = 1'b1;
      end
    join
    repeat (8) step();
    chk("bp_count", got_u.size(), 4);
    chk("bp_0", got_u[0], 11'd64);
    chk("bp_1", got_u[1], 11'd8);
    chk("bp_2", got_u[2], 11'd2040);
    chk("bp_3", got_u[3], 11'd16);

    // reset with two vectors in flight
    clear_got();
    push(odd);
    push(rep(8'd255));
    rst = 1'b1;
    step();
    chk("midrst_out_valid", out_valid_u, 0);
    chk("midrst_out_sum", out_sum_u, 0);
    chk("midrst_in_ready", in_ready_u, 1);
    rst = 1'b0;
    repeat (10) step();
    chk("midrst_no_stale", got_u.size(), 0);

`ifdef PES_ADD_ACC_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("acc_rst", acc_u, 0);
    push(odd);
    push(odd);
    push(odd);
    repeat (8) step();
    chk("acc_192_u", acc_u, 192);
    chk("acc_192_s", acc_s, 192);
    push(rep(8'd1));
    lat = 0;
    while (!out_valid_u && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    acc_clear = 1'b1;
    step();
    acc_clear = 1'b0;
    chk("acc_clear_xfer", acc_u, 8);
    chk("acc_clear_xfer_s", acc_s, 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("acc_rst_again", acc_u, 0);
`endif

    // randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    chk("final_drained", sb_u.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
